// File: rtl/hmc_rsp_flit_scheduler.sv
// Response-flit scheduler: round-robin shares the FPW-wide PHY receive word between two
// requesters, packing each packet's flits from slot 0 and zero-padding its final word.
module hmc_rsp_flit_scheduler #(
    parameter  int FPW       = 4,
    parameter  int FLIT_SIZE = 128,
    parameter  int CNT_W     = 16,
    localparam int DWIDTH    = FPW * FLIT_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    input  logic [2*FLIT_SIZE-1:0] req_flit,
    output logic [1:0]             req_ready,
    output logic [DWIDTH-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   err,
    output logic [CNT_W-1:0]       pkt_cnt
);
    localparam int SW = $clog2(FPW + 1);

    typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;

    state_t                        state_q, state_d;
    logic                          rr_q, rr_d;
    logic                          grant_q, grant_d;
    logic                          hdr_q, hdr_d;
    logic                          out_valid_q, out_valid_d;
    logic                          err_q, err_d;
    logic [SW-1:0]                 slot_q, slot_d;
    logic [3:0]                    rem_q, rem_d;
    logic [FPW-1:0][FLIT_SIZE-1:0] data_q, data_d;
    logic [CNT_W-1:0]              pkt_cnt_q, pkt_cnt_d;

    logic [FLIT_SIZE-1:0] flit;
    logic [3:0]           lng;
    logic [3:0]           rem_n;
    logic                 accept;

    assign flit   = grant_q ? req_flit[FLIT_SIZE +: FLIT_SIZE] : req_flit[0 +: FLIT_SIZE];
    assign lng    = flit[10:7];
    assign accept = (state_q == XFER) && req_valid[grant_q];

    assign req_ready = (state_q == XFER) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign out_data  = data_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign pkt_cnt   = pkt_cnt_q;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        hdr_d       = hdr_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        slot_d      = slot_q;
        rem_d       = rem_q;
        data_d      = data_q;
        pkt_cnt_d   = pkt_cnt_q;
        rem_n       = 4'd0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = req_valid[rr_q] ? rr_q : ~rr_q;
                    hdr_d   = 1'b1;
                    slot_d  = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (accept) begin
                    hdr_d = 1'b0;
                    if (hdr_q && (lng == 4'd0 || lng > 4'd9)) begin
                        // Bad header: drop it and hand the next turn to the other side.
                        err_d   = 1'b1;
                        rr_d    = ~grant_q;
                        state_d = IDLE;
                    end else begin
                        rem_n = hdr_q ? lng - 4'd1 : rem_q - 4'd1;
                        for (int k = 0; k < FPW; k++) begin
                            if (slot_q == SW'(k)) data_d[k] = flit;
                        end
                        slot_d = slot_q + 1'b1;
                        rem_d  = rem_n;
                        // Unwritten slots are already zero because the buffer clears per word.
                        if (slot_d == SW'(FPW) || rem_n == 4'd0) begin
                            out_valid_d = 1'b1;
                            state_d     = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    data_d      = '0;
                    if (rem_q != 4'd0) begin
                        slot_d  = '0;
                        state_d = XFER;
                    end else begin
                        pkt_cnt_d = pkt_cnt_q + 1'b1;
                        rr_d      = ~rr_q;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            grant_q     <= 1'b0;
            hdr_q       <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            slot_q      <= '0;
            rem_q       <= 4'd0;
            data_q      <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            hdr_q       <= hdr_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            slot_q      <= slot_d;
            rem_q       <= rem_d;
            data_q      <= data_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end
endmodule

// File: tb/tb_hmc_rsp_flit_scheduler.sv
// Bench for hmc_rsp_flit_scheduler: expected words are queued from packet contents at issue
// time and a negedge monitor pops and compares them on each output handshake.
module tb_hmc_rsp_flit_scheduler;
    localparam int FPW = 4, FS = 128, CNT_W = 16, DW = FPW * FS;
    localparam int NPK = 12, TMO = 300;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              v0 = 1'b0, v1 = 1'b0;
    logic [FS-1:0]     f0 = '0, f1 = '0;
    logic [1:0]        req_valid, req_ready;
    logic [2*FS-1:0]   req_flit;
    logic [DW-1:0]     out_data;
    logic              out_valid, err;
    logic              out_ready = 1'b1;
    logic [CNT_W-1:0]  pkt_cnt;

    assign req_valid = {v1, v0};
    assign req_flit  = {f1, f0};

    always #5 clk = ~clk;

    hmc_rsp_flit_scheduler #(.FPW(FPW), .FLIT_SIZE(FS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_flit(req_flit),
        .req_ready(req_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .err(err), .pkt_cnt(pkt_cnt)
    );

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
    } exp_t;

    exp_t          exp_q[$];
    logic [FS-1:0] pf [2][NPK][9];
    int            plen [2][NPK];
    bit            pbad [2][NPK];
    int            checks = 0, errors = 0;
    int            err_seen = 0, exp_pkt = 0, both_rdy = 0;
    bit            done = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: packet count at a handshake reflects only packets completed before it.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_pkt = 0;
        end else begin
            if (err) err_seen++;
            if (&req_ready) both_rdy++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", out_data, e.data);
                    chk("pkt_cnt_at_hs", DW'(pkt_cnt), DW'(exp_pkt % (1 << CNT_W)));
                    if (e.last) exp_pkt++;
                end
            end
        end
    end

    function automatic void make_pkt(input int r, input int i, input logic [3:0] lng, input bit seq);
        logic [FS-1:0] x;
        pbad[r][i] = (lng == 4'd0 || lng > 4'd9);
        plen[r][i] = pbad[r][i] ? 1 : int'(lng);
        for (int k = 0; k < 9; k++) begin
            x = seq ? ((FS'(r) << 124) | (FS'(k) << 16)) : {$urandom, $urandom, $urandom, $urandom};
            if (k == 0) x[10:7] = lng;
            pf[r][i][k] = x;
        end
    endfunction

    // Model: a packet's flits are chunked FPW at a time from slot 0; the tail word is zero-filled.
    task automatic push_exp(input int r, input int i);
        exp_t e;
        if (pbad[r][i]) return;
        for (int w = 0; w < plen[r][i]; w += FPW) begin
            e.data = '0;
            for (int s = 0; s < FPW; s++)
                if (w + s < plen[r][i]) e.data[s*FS +: FS] = pf[r][i][w+s];
            e.last = (w + FPW >= plen[r][i]);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_flit(input int r, input logic [FS-1:0] x);
        int n = 0;
        if (r == 0) begin v0 = 1'b1; f0 = x; end
        else begin v1 = 1'b1; f1 = x; end
        while (1) begin
            @(negedge clk);
            if (req_ready[r]) break;
            n++;
            if (n >= TMO) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout req=%0d actual=stalled required=accept", r);
                break;
            end
        end
        @(posedge clk); #1;
        if (r == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic drive_pkt(input int r, input int i, input int gap);
        for (int k = 0; k < plen[r][i]; k++) begin
            if (k > 0 && gap > 0)
                repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
            send_flit(r, pf[r][i][k]);
        end
    endtask

    task automatic drive_list(input int r, input int n, input int gap);
        for (int i = 0; i < n; i++) drive_pkt(r, i, gap);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 4 * TMO) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", DW'(exp_q.size()), DW'(0));
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", DW'(out_valid), DW'(0));
        chk("rst_req_ready", DW'(req_ready), DW'(0));
        chk("rst_pkt_cnt", DW'(pkt_cnt), DW'(0));
        chk("rst_out_data", out_data, '0);
    endtask

    // With both requesters always holding a header, service strictly alternates from 'first'.
    task automatic run_dual(input int n, input int gap, input bit rnd, input int first);
        for (int i = 0; i < n; i++) begin
            push_exp(first, i);
            push_exp(1 - first, i);
        end
        done = 1'b0;
        fork
            begin
                fork
                    drive_list(0, n, gap);
                    drive_list(1, n, gap);
                join
                done = 1'b1;
            end
            begin
                if (rnd)
                    while (!done) begin
                        @(posedge clk); #1;
                        out_ready = ($urandom_range(0, 3) != 0);
                    end
                else
                    wait (done);
                out_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w0;
        logic [3:0]    lng;
        int            n, good, bad, ebase;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("init_out_valid", DW'(out_valid), DW'(0));
        chk("init_req_ready", DW'(req_ready), DW'(0));
        chk("init_err", DW'(err), DW'(0));
        chk("init_pkt_cnt", DW'(pkt_cnt), DW'(0));

        // Single-flit packet with request and output latency checks.
        make_pkt(0, 0, 4'd1, 1'b1);
        push_exp(0, 0);
        @(posedge clk); #1;
        v0 = 1'b1; f0 = pf[0][0][0];
        @(negedge clk);
        chk("idle_req_ready", DW'(req_ready), DW'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("req_ready_lat", DW'(req_ready), DW'(2'b01));
        @(posedge clk); #1;
        v0 = 1'b0;
        @(negedge clk);
        chk("out_valid_lat", DW'(out_valid), DW'(1));
        wait_drain();
        chk("pkt_cnt_lng1", DW'(pkt_cnt), DW'(1));

        // Nine-flit packet spanning three words.
        make_pkt(1, 0, 4'd9, 1'b1);
        push_exp(1, 0);
        drive_pkt(1, 0, 0);
        wait_drain();
        chk("pkt_cnt_lng9", DW'(pkt_cnt), DW'(2));
        chk("no_err_legal", DW'(err_seen), DW'(0));

        // Both requesters streaming from reset.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 2; i++) make_pkt(r, i, 4'd2, 1'b0);
        run_dual(2, 0, 1'b0, 0);
        chk("pkt_cnt_rr", DW'(pkt_cnt), DW'(4));

        // Output back-pressure holds the first word stable.
        make_pkt(0, 0, 4'd5, 1'b1);
        w0 = '0;
        for (int s = 0; s < FPW; s++) w0[s*FS +: FS] = pf[0][0][s];
        push_exp(0, 0);
        out_ready = 1'b0;
        fork
            drive_pkt(0, 0, 0);
            begin
                n = 0;
                while (!out_valid && n < TMO) begin @(negedge clk); n++; end
                for (int c = 0; c < 6; c++) begin
                    chk("hold_valid", DW'(out_valid), DW'(1));
                    chk("hold_data", out_data, w0);
                    chk("hold_req_ready", DW'(req_ready), DW'(0));
                    @(negedge clk);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Illegal headers.
        do_reset();
        ebase = err_seen;
        make_pkt(0, 0, 4'd0, 1'b1);
        send_flit(0, pf[0][0][0]);
        @(negedge clk);
        chk("err_pulse_lng0", DW'(err), DW'(1));
        @(negedge clk);
        chk("err_clear_lng0", DW'(err), DW'(0));
        make_pkt(0, 1, 4'd12, 1'b1);
        send_flit(0, pf[0][1][0]);
        @(negedge clk);
        chk("err_pulse_lng12", DW'(err), DW'(1));
        @(negedge clk);
        chk("err_clear_lng12", DW'(err), DW'(0));
        chk("err_count_bad", DW'(err_seen - ebase), DW'(2));
        chk("pkt_cnt_bad", DW'(pkt_cnt), DW'(0));
        chk("out_valid_bad", DW'(out_valid), DW'(0));
        make_pkt(0, 0, 4'd1, 1'b1);
        make_pkt(1, 0, 4'd1, 1'b1);
        run_dual(1, 0, 1'b0, 1);

        // Reset in the middle of a packet.
        make_pkt(0, 0, 4'd9, 1'b1);
        send_flit(0, pf[0][0][0]);
        send_flit(0, pf[0][0][1]);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", DW'(out_valid), DW'(0));
        chk("midrst_req_ready", DW'(req_ready), DW'(0));
        chk("midrst_pkt_cnt", DW'(pkt_cnt), DW'(0));
        make_pkt(0, 1, 4'd1, 1'b1);
        push_exp(0, 1);
        drive_pkt(0, 1, 0);
        wait_drain();
        chk("pkt_cnt_after_rst", DW'(pkt_cnt), DW'(1));

        // Randomized traffic with stalls, back-pressure and occasional bad headers.
        for (int round = 0; round < 3; round++) begin
            do_reset();
            good = 0;
            bad = 0;
            for (int r = 0; r < 2; r++)
                for (int i = 0; i < NPK; i++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        n = $urandom_range(0, 6);
                        lng = (n == 0) ? 4'd0 : 4'(9 + n);
                        bad++;
                    end else begin
                        lng = 4'($urandom_range(1, 9));
                        good++;
                    end
                    make_pkt(r, i, lng, 1'b0);
                end
            ebase = err_seen;
            run_dual(NPK, 3, 1'b1, 0);
            chk("rand_pkt_cnt", DW'(pkt_cnt), DW'(good));
            chk("rand_err_count", DW'(err_seen - ebase), DW'(bad));
        end

        chk("ready_onehot", DW'(both_rdy), DW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
